// File: rtl/seven_seg_readback_pkg.sv
// Shared types and constants for the seven-segment readback checker.
// Segment vectors are ordered {G,F,E,D,C,B,A}, bit 0 = segment A.
package seven_seg_readback_pkg;

  localparam int SEG_W = 7;
  localparam int SEG_PAIR_W = 2 * SEG_W;

  // Active-high hex glyphs as driven by the segment driver
  localparam logic [SEG_W-1:0] PAT_0 = 7'h3F;
  localparam logic [SEG_W-1:0] PAT_1 = 7'h06;
  localparam logic [SEG_W-1:0] PAT_2 = 7'h5B;
  localparam logic [SEG_W-1:0] PAT_3 = 7'h4F;
  localparam logic [SEG_W-1:0] PAT_4 = 7'h66;
  localparam logic [SEG_W-1:0] PAT_5 = 7'h6D;
  localparam logic [SEG_W-1:0] PAT_6 = 7'h7D;
  localparam logic [SEG_W-1:0] PAT_7 = 7'h07;
  localparam logic [SEG_W-1:0] PAT_8 = 7'h7F;
  localparam logic [SEG_W-1:0] PAT_9 = 7'h6F;
  localparam logic [SEG_W-1:0] PAT_A = 7'h77;
  localparam logic [SEG_W-1:0] PAT_B = 7'h7C;
  localparam logic [SEG_W-1:0] PAT_C = 7'h39;
  localparam logic [SEG_W-1:0] PAT_D = 7'h5E;
  localparam logic [SEG_W-1:0] PAT_E = 7'h79;
  localparam logic [SEG_W-1:0] PAT_F = 7'h71;

  typedef struct packed {
    logic       valid;
    logic [3:0] nibble;
  } digit_dec_t;

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_HOLD   = 1'b1
  } state_t;

endpackage

// File: rtl/seven_seg_readback_char_decode.sv
// Combinational glyph decoder: one 7-bit active-high segment pattern to a hex
// nibble plus a valid flag; anything outside the 16 glyphs is invalid.
module seven_seg_char_decode
  import seven_seg_readback_pkg::*;
(
  input  logic [SEG_W-1:0] i_seg,
  output digit_dec_t       o_dec
);

  always_comb begin
    o_dec = '{valid: 1'b1, nibble: 4'h0};
    case (i_seg)
      PAT_0: o_dec.nibble = 4'h0;
      PAT_1: o_dec.nibble = 4'h1;
      PAT_2: o_dec.nibble = 4'h2;
      PAT_3: o_dec.nibble = 4'h3;
      PAT_4: o_dec.nibble = 4'h4;
      PAT_5: o_dec.nibble = 4'h5;
      PAT_6: o_dec.nibble = 4'h6;
      PAT_7: o_dec.nibble = 4'h7;
      PAT_8: o_dec.nibble = 4'h8;
      PAT_9: o_dec.nibble = 4'h9;
      PAT_A: o_dec.nibble = 4'hA;
      PAT_B: o_dec.nibble = 4'hB;
      PAT_C: o_dec.nibble = 4'hC;
      PAT_D: o_dec.nibble = 4'hD;
      PAT_E: o_dec.nibble = 4'hE;
      PAT_F: o_dec.nibble = 4'hF;
      default: o_dec.valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_seg_readback.sv
// Two-digit seven-segment readback: synchronise, wait for a stable sample,
// decode to a byte, strobe new values / errors. SEVEN_SEG_READBACK_ACTIVE_LOW_EN
// selects active-low segment wiring.
//
// state  | meaning
// SETTLE | counting consecutive identical samples before evaluating
// HOLD   | current sample already evaluated, waiting for the next change
module seven_seg_readback
  import seven_seg_readback_pkg::*;
#(
  parameter int STABLE_CYCLES = 16
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic [SEG_W-1:0] i_Seg1,
  input  logic [SEG_W-1:0] i_Seg2,
  output logic [7:0]       o_Value,
  output logic             o_Valid,
  output logic             o_Step,
  output logic             o_Error,
  output logic [7:0]       o_ErrCount
);

`ifdef SEVEN_SEG_READBACK_ACTIVE_LOW_EN
  localparam logic [SEG_PAIR_W-1:0] INV_MASK = '1;
`else
  localparam logic [SEG_PAIR_W-1:0] INV_MASK = '0;
`endif

  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  logic [SEG_PAIR_W-1:0] sync1_q, sync1_d, sync2_q, sync2_d, samp_q, samp_d;
  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [7:0]            value_q, value_d;
  logic [7:0]            errcnt_q, errcnt_d;
  logic                  valid_q, valid_d, step_q, step_d, error_q, error_d;
  logic                  has_prev_q, has_prev_d;

  logic [SEG_PAIR_W-1:0] cmp_seg;
  digit_dec_t            dec_hi, dec_lo;
  logic [7:0]            decoded;
  logic                  changed, eval;

  // Changed compares the value about to be sampled against the held sample,
  // so a change clears the counter on the same edge that captures it.
  assign changed = (sync2_q != samp_q);
  assign cmp_seg = samp_q ^ INV_MASK;
  assign decoded = {dec_hi.nibble, dec_lo.nibble};

  seven_seg_char_decode u_dec_hi (.i_seg(cmp_seg[SEG_PAIR_W-1:SEG_W]), .o_dec(dec_hi));
  seven_seg_char_decode u_dec_lo (.i_seg(cmp_seg[SEG_W-1:0]),          .o_dec(dec_lo));

  always_comb begin
    sync1_d    = {i_Seg1, i_Seg2};
    sync2_d    = sync1_q;
    samp_d     = sync2_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    value_d    = value_q;
    errcnt_d   = errcnt_q;
    has_prev_d = has_prev_q;
    valid_d    = 1'b0;
    step_d     = 1'b0;
    error_d    = 1'b0;
    eval       = 1'b0;

    case (state_q)
      ST_SETTLE: begin
        if (changed) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          eval    = 1'b1;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_HOLD: begin
        if (changed) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_SETTLE;
    endcase

    if (eval) begin
      if (dec_hi.valid && dec_lo.valid) begin
        if (!has_prev_q || decoded != value_q) begin
          value_d    = decoded;
          valid_d    = 1'b1;
          step_d     = has_prev_q && (decoded == value_q + 8'd1);
          has_prev_d = 1'b1;
        end
      end else begin
        error_d = 1'b1;
        if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      samp_q     <= '0;
      state_q    <= ST_SETTLE;
      cnt_q      <= '0;
      value_q    <= '0;
      errcnt_q   <= '0;
      has_prev_q <= 1'b0;
      valid_q    <= 1'b0;
      step_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      samp_q     <= samp_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      value_q    <= value_d;
      errcnt_q   <= errcnt_d;
      has_prev_q <= has_prev_d;
      valid_q    <= valid_d;
      step_q     <= step_d;
      error_q    <= error_d;
    end
  end

  assign o_Value    = value_q;
  assign o_Valid    = valid_q;
  assign o_Step     = step_q;
  assign o_Error    = error_q;
  assign o_ErrCount = errcnt_q;

endmodule
